// File: rtl/dmem_responder_if.sv
// Request/response bundle between the EXU memory port and the data memory.
// master: EXU (drives req_*, rsp_ready); slave: responder (drives req_ready, rsp_*).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wen, req_addr,
    output req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr,
    input  req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: doubleword array, byte-masked stores, LAT-cycle
// response delay, one request in flight. Ports: clk, rst_n, dmem (slave).
module dmem_responder #(
  parameter int          AW   = 10,
  parameter int          LAT  = 2,
  parameter logic [63:0] BASE = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_responder_if.slave dmem
);

  localparam int          DEPTH = 1 << AW;
  localparam logic [63:0] SPAN  = 64'(DEPTH) << 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [63:0] mem_q [DEPTH];

  logic [63:0]   off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          accept;
  logic          wr_en;

  // Below-BASE addresses wrap to a huge offset and fail the range test.
  assign off      = dmem.req_addr - BASE;
  assign in_range = off < SPAN;
  assign idx      = off[AW+2:3];
  assign accept   = (state_q == S_IDLE) && dmem.req_valid;
  assign wr_en    = accept && dmem.req_wen && in_range;

  assign dmem.req_ready = (state_q == S_IDLE);
  assign dmem.rsp_valid = (state_q == S_RESP);
  assign dmem.rsp_rdata = rdata_q;
  assign dmem.rsp_err   = err_q;

  // Storage is deliberately not reset; a store committed before a
  // reset survives it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (dmem.req_wmask[i]) begin
          mem_q[idx][8*i +: 8] <= dmem.req_wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (LAT == 1) ? S_RESP : S_WAIT;
          cnt_d   = 4'(LAT - 1);
          rdata_d = (in_range && !dmem.req_wen) ? mem_q[idx] : '0;
          err_d   = !in_range;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (dmem.rsp_ready) begin
          state_d = S_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed loads/stores on a LAT=2
// instance, latency and throughput on LAT=1 and LAT=15 instances.
module tb_dmem_responder;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int LATS [3] = '{2, 1, 15};

  typedef struct {
    logic [63:0] d;
    logic        e;
  } exp_t;

  logic clk;
  logic rst_n;

  dmem_responder_if b0 ();
  dmem_responder_if b1 ();
  dmem_responder_if b2 ();

  dmem_responder #(.AW(10), .LAT(2), .BASE(BASE)) u0 (
    .clk(clk), .rst_n(rst_n), .dmem(b0));
  dmem_responder #(.AW(10), .LAT(1), .BASE(BASE)) u1 (
    .clk(clk), .rst_n(rst_n), .dmem(b1));
  dmem_responder #(.AW(10), .LAT(15), .BASE(BASE)) u2 (
    .clk(clk), .rst_n(rst_n), .dmem(b2));

  logic rv [3];
  logic rr [3];
  logic qv [3];
  logic qr [3];

  assign rv[0] = b0.rsp_valid;
  assign rv[1] = b1.rsp_valid;
  assign rv[2] = b2.rsp_valid;
  assign rr[0] = b0.rsp_ready;
  assign rr[1] = b1.rsp_ready;
  assign rr[2] = b2.rsp_ready;
  assign qv[0] = b0.req_valid;
  assign qv[1] = b1.req_valid;
  assign qv[2] = b2.req_valid;
  assign qr[0] = b0.req_ready;
  assign qr[1] = b1.req_ready;
  assign qr[2] = b2.req_ready;

  exp_t sb [$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  int   acc_edge [3];
  int   last_acc [3];
  int   n_acc    [3];
  bit   pend     [3];
  bit   tp_en    [3];

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: edge numbers are those of the upcoming rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        pend[k]     = 1'b0;
        last_acc[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (qv[k] && qr[k]) begin
          if (tp_en[k] && last_acc[k] != 0)
            chk("accept_period", 64'(cyc + 1 - last_acc[k]),
                64'(LATS[k] + 1));
          last_acc[k] = cyc + 1;
          acc_edge[k] = cyc + 1;
          pend[k]     = 1'b1;
          n_acc[k]++;
        end
        if (rv[k] && pend[k]) begin
          chk("latency", 64'(cyc + 1 - acc_edge[k]), 64'(LATS[k]));
          pend[k] = 1'b0;
        end
      end
    end
    if (rv[0] && rr[0]) begin
      if (sb.size() == 0) begin
        chk("spurious_rsp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", b0.rsp_rdata, e.d);
        chk("rsp_err", 64'(b0.rsp_err), 64'(e.e));
      end
    end
  end

  task automatic issue(input logic wen, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] mask,
                       input logic [63:0] exp_d, input logic exp_e);
    bit got;
    got = 1'b0;
    sb.push_back('{d: exp_d, e: exp_e});
    b0.req_valid = 1'b1;
    b0.req_wen   = wen;
    b0.req_addr  = addr;
    b0.req_wdata = wdata;
    b0.req_wmask = mask;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b0.req_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    b0.req_valid = 1'b0;
    chk("accept", 64'(got), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus(input int k);
    case (k)
      1: begin
        b1.req_valid = 0; b1.req_wen = 1; b1.req_addr = BASE + 8;
        b1.req_wdata = 0; b1.req_wmask = 8'hFF; b1.rsp_ready = 1;
      end
      2: begin
        b2.req_valid = 0; b2.req_wen = 1; b2.req_addr = BASE + 8;
        b2.req_wdata = 0; b2.req_wmask = 8'hFF; b2.rsp_ready = 1;
      end
      default: begin
        b0.req_valid = 0; b0.req_wen = 0; b0.req_addr = BASE;
        b0.req_wdata = 0; b0.req_wmask = 0; b0.rsp_ready = 1;
      end
    endcase
  endtask

  initial begin
    bit got;
    for (int k = 0; k < 3; k++) begin
      acc_edge[k] = 0; last_acc[k] = 0; n_acc[k] = 0;
      pend[k] = 0; tp_en[k] = 0;
      idle_bus(k);
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_ready", 64'(b0.req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(b0.rsp_valid), 64'd0);
    chk("rst_rsp_rdata", b0.rsp_rdata, 64'd0);
    chk("rst_rsp_err", 64'(b0.rsp_err), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // store then load
    issue(1, BASE + 64'h10, 64'h1122334455667788, 8'hFF, 64'd0, 0);
    drain();
    issue(0, BASE + 64'h10, 64'h0, 8'h00, 64'h1122334455667788, 0);
    drain();

    // byte mask, then no-op mask
    issue(1, BASE + 64'h18, 64'h1122334455667788, 8'hFF, 64'd0, 0);
    drain();
    issue(1, BASE + 64'h18, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'd0, 0);
    drain();
    issue(0, BASE + 64'h18, 64'h0, 8'hFF, 64'h11223344AAAAAAAA, 0);
    drain();
    issue(1, BASE + 64'h18, 64'hFFFFFFFFFFFFFFFF, 8'h00, 64'd0, 0);
    drain();
    issue(0, BASE + 64'h18, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 0);
    drain();

    // range edges
    issue(1, BASE, 64'hDEADBEEFCAFEF00D, 8'hFF, 64'd0, 0);
    drain();
    issue(0, 64'h7FFF_FFF8, 64'h0, 8'hFF, 64'd0, 1);
    drain();
    issue(1, BASE + 64'h2000, 64'h5555555555555555, 8'hFF, 64'd0, 1);
    drain();
    issue(0, BASE, 64'h0, 8'h00, 64'hDEADBEEFCAFEF00D, 0);
    drain();
    issue(1, BASE + 64'h1FF8, 64'h0123456789ABCDEF, 8'hFF, 64'd0, 0);
    drain();
    issue(0, BASE + 64'h1FF8, 64'h0, 8'h00, 64'h0123456789ABCDEF, 0);
    drain();

    // backpressure; req_* changes while busy must be ignored
    b0.rsp_ready = 1'b0;
    issue(0, BASE + 64'h10, 64'h0, 8'h00, 64'h1122334455667788, 0);
    b0.req_wen   = 1'b1;
    b0.req_addr  = BASE + 64'h18;
    b0.req_wdata = 64'h0;
    b0.req_wmask = 8'hFF;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b0.rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("bp_rise", 64'(got), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(b0.rsp_valid), 64'd1);
      chk("bp_rdata", b0.rsp_rdata, 64'h1122334455667788);
      chk("bp_req_ready", 64'(b0.req_ready), 64'd0);
    end
    @(posedge clk);
    #1 b0.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_valid", 64'(b0.rsp_valid), 64'd0);
    chk("bp_release_ready", 64'(b0.req_ready), 64'd1);
    @(posedge clk);
    #1;
    issue(0, BASE + 64'h18, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 0);
    drain();

    // async reset during WAIT of a store
    issue(1, BASE + 64'h20, 64'hFEEDFACE01020304, 8'hFF, 64'd0, 0);
    chk("wait_state", 64'(b0.req_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_ready", 64'(b0.req_ready), 64'd1);
    chk("arst_rsp_valid", 64'(b0.rsp_valid), 64'd0);
    chk("arst_rsp_rdata", b0.rsp_rdata, 64'd0);
    chk("arst_rsp_err", 64'(b0.rsp_err), 64'd0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(0, BASE + 64'h20, 64'h0, 8'h00, 64'hFEEDFACE01020304, 0);
    drain();

    // throughput, LAT=1
    tp_en[1] = 1'b1;
    b1.req_valid = 1'b1;
    repeat (12) @(posedge clk);
    #1 b1.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    chk("lat1_accepts", 64'(n_acc[1] >= 5), 64'd1);

    // throughput, LAT=15
    tp_en[2] = 1'b1;
    b2.req_valid = 1'b1;
    repeat (70) @(posedge clk);
    #1 b2.req_valid = 1'b0;
    repeat (20) @(posedge clk);
    chk("lat15_accepts", 64'(n_acc[2] >= 4), 64'd1);

    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder that answers load/store requests issued by the execute stage over a valid/ready request/response protocol.
- Holds a word-addressed, doubleword-wide storage array with byte-masked writes.
- Inserts a programmable access latency so the EXU's multi-cycle memory-wait path can be exercised.
- Sits between the EXU memory port and the simulation top; one outstanding request at a time.

Parameters:
- AW, 10, index width; array depth = 2^AW doublewords.
- LAT, 2, cycles from request acceptance to rsp_valid assertion; legal range 1..15.
- BASE, 64'h8000_0000, byte address mapped to array index 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address; bits [2:0] ignored (doubleword aligned).
- req_wdata  in  64  store data.
- req_wmask  in  8  byte enables for stores; bit i enables byte i (wdata[8i+7:8i]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  64  load data; 0 for stores and for errors.
- rsp_err  out  1  address outside [BASE, BASE + 8*2^AW).

Behaviour:
- Reset (async, active-low): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. Array contents are not reset.
- States:
  - IDLE: req_ready=1.
  - WAIT: req_ready=0; counter counting.
  - RESP: req_ready=0, rsp_valid=1.
- Acceptance: a request is accepted on a rising edge when state=IDLE and req_valid=1. The same edge:
  - computes index = (req_addr - BASE) >> 3 and the range check;
  - for an in-range store, commits the masked write (unmasked bytes unchanged);
  - for an in-range load, captures the array word into the response register;
  - for an out-of-range request, performs no write, captures rdata=0, err=1;
  - loads counter with LAT-1.
- Transitions:
  - IDLE -> RESP directly if LAT=1; otherwise IDLE -> WAIT.
  - WAIT: counter decrements each cycle; at counter==1 the next state is RESP. rsp_valid therefore rises exactly LAT cycles after the acceptance edge.
  - RESP: rsp_valid, rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready at a rising edge; then state -> IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Back-to-back: no request is accepted in the cycle the response handshakes (req_ready is low in RESP); the next acceptance occurs at the earliest on the following edge. Throughput is one request per LAT+1 cycles.
- Store response: rsp_valid is asserted with rsp_rdata=0. req_wmask=0 is a legal no-op store that still responds.
- Load masking: req_wmask is ignored for loads; the full 64-bit word is returned and sign/zero extension is the EXU's job.
- Request inputs are sampled only at the acceptance edge; changes on req_* while in WAIT/RESP have no effect.
- rsp_ready asserted outside RESP is ignored.
- Reset mid-operation: the pending response is dropped and state -> IDLE. A store already committed at acceptance remains in the array.
- Address arithmetic is 64-bit unsigned. req_addr < BASE wraps to a huge offset and is flagged as out of range.

Test Plan:
- Store then load, LAT=2: store addr 0x8000_0010, wdata 0x1122334455667788, mask 0xFF -> rsp_valid 2 cycles after accept, rdata 0. Load same addr -> rdata 0x1122334455667788, err 0.
- Byte mask: preload 0x1122334455667788; store wdata 0xAAAAAAAAAAAAAAAA, mask 0x0F; load -> 0x11223344AAAAAAAA.
- Backpressure: load with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata held constant, req_ready=0 throughout. Raise rsp_ready -> next cycle rsp_valid=0, req_ready=1.
- Out of range: load 0x7FFF_FFF8 and store 0x8000_2000 (AW=10) -> rsp_err=1, rdata 0. A subsequent load at index 0 shows contents unchanged.
- Latency sweep: LAT=1 and LAT=15 -> rsp_valid rises exactly 1 and 15 cycles after acceptance. Continuous req_valid with rsp_ready=1 yields one accept per LAT+1 cycles.
- Async reset: deassert rst_n during WAIT of a store to 0x8000_0020 -> outputs return to reset values immediately without a clock edge. After release, a load of 0x8000_0020 returns the stored data.
